bin_clock_timekeeper: RTL and testbench
=======================================

// Module: bin_clock_timekeeper
// PURPOSE
//  Timekeeping controller for the binary clock: drives the hour/minute/second registers shown on the LEDs.
//  Generates the 1 Hz tick from the system clock and runs the H:M:S carry chain (12-hour, no AM/PM).
//  Arbitrates between run mode and set mode, where push buttons adjust one field at a time.
//  Sits between the raw top-level inputs and the display outputs of tt_bin_clock.
// PARAMETERS
//  CLK_HZ       10_000_000   clk_i cycles per second; prescaler terminal count is CLK_HZ-1
//  SYNC_STAGES  2            flops in each input synchronizer (>=2)
//  HOLD_CYC     CLK_HZ/2     cycles a button stays held before auto-repeat starts
//  RPT_CYC      CLK_HZ/8     cycles between auto-repeat steps
// PORTS
//  clk_i        in   1  system clock
//  rst_i        in   1  synchronous, active-high reset
//  time_set     in   1  async level: 1 = set mode, 0 = run mode
//  id_switch    in   1  async level: 1 = increment, 0 = decrement
//  hour_id      in   1  async button: adjust hours
//  minute_id    in   1  async button: adjust minutes
//  seconds_id   in   1  async button: adjust seconds
//  hour_out     out  4  hours, 1..12
//  minute_out   out  6  minutes, 0..59
//  seconds_out  out  6  seconds, 0..59
//  tick_o       out  1  one-cycle pulse, coincident with each run-mode seconds advance
//  set_mode_o   out  1  registered FSM state: 1 = SET
// BEHAVIOUR
//  Reset values: hour_out=12, minute_out=0, seconds_out=0, tick_o=0, set_mode_o=0 (RUN).
//    Prescaler, synchronizer, edge and repeat registers are also cleared to 0.
//  Sync: all five inputs pass through SYNC_STAGES flops; downstream logic uses synchronized levels only.
//  FSM, 2 states:
//    RUN->SET on the edge after sync time_set=1.
//    SET->RUN on the edge after sync time_set=0.
//  RUN:
//    Prescaler counts 0..CLK_HZ-1. At terminal count it wraps to 0 and seconds advance; tick_o=1 that cycle.
//    Carries ripple on the same edge: sec 59->0 adds a minute; min 59->0 adds an hour; hr 12->1.
//    Example: 12:59:59 -> 1:00:00 on one edge.
//    Buttons are ignored.
//  SET:
//    Prescaler is held at 0 and tick_o=0.
//    On SET->RUN the prescaler starts at 0, so the first tick comes exactly CLK_HZ cycles after set_mode_o falls.
//  Adjust pulse: rising edge of a sync button while set_mode_o=1, plus auto-repeat.
//    Auto-repeat: once held HOLD_CYC cycles, one pulse every RPT_CYC cycles until released.
//    Per-button repeat counter; cleared on release or in RUN.
//  Field update: the edge after an adjust pulse.
//    Overall latency is SYNC_STAGES+1 edges after the edge that first samples the raw button high.
//  Adjust direction: id_switch sampled in the pulse cycle.
//    Inc wrap: sec/min 59->0, hr 12->1. Dec wrap: sec/min 0->59, hr 1->12.
//    No carry between fields in SET mode.
//  Simultaneous buttons: each pulsed field adjusts independently on the same edge.
//  Held through mode change: a button held while entering SET, or held through reset, makes no adjustment.
//    Its edge register already tracks 1, or the edge falls in a RUN cycle.
//    The first adjustment needs a release and a fresh press.
//  Reset mid-operation: all registers return to reset values on the next edge, overriding tick, carry and adjust.
//  Arithmetic: out-of-range values are unreachable; an illegal value (e.g. hr 0 or 13) is corrected to the reset value on the next update.
// TESTING (sim with CLK_HZ=8, HOLD_CYC=6, RPT_CYC=2)
//  Reset, run 8*3600*12 cycles -> tick_o every 8 cycles; time returns to 12:00:00; 12:59:59 -> 1:00:00 on one edge.
//  time_set=1, id=1, pulse minute_id at 59 -> minute_out=0, hour_out unchanged.
//    Update lands 3 edges after sample; no ticks while in SET.
//  id=0, hour_id pulse at hr=1 -> 12; seconds_id pulse at 0 -> 59 with hour_id on the same cycle -> both update on the same edge.
//  Hold minute_id 12 cycles in SET, id=1, from 10 -> 1 (press) + repeats after 6 cycles every 2 -> minute_out=14.
//  Buttons held across reset release, and across RUN->SET -> no change until release and re-press.
//  time_set 1->0 -> set_mode_o falls 3 edges later; first tick_o exactly 8 cycles after that.
//    rst_i mid-count -> 12:00:00, prescaler 0.

Source files
------------

// File: rtl/bin_clock_timekeeper.sv
// -----------------------------------------------------------------------------
// bin_clock_timekeeper
//
// Timekeeping controller for the binary clock. Generates the 1 Hz tick from the
// system clock, runs the 12-hour H:M:S carry chain, and lets the user adjust one
// field at a time in set mode with press and auto-repeat push buttons.
//
// Ports
//   clk_i        in   system clock
//   rst_i        in   synchronous, active-high reset
//   time_set     in   async level: 1 = set mode, 0 = run mode
//   id_switch    in   async level: 1 = increment, 0 = decrement
//   hour_id      in   async button: adjust hours
//   minute_id    in   async button: adjust minutes
//   seconds_id   in   async button: adjust seconds
//   hour_out     out  hours, 1..12
//   minute_out   out  minutes, 0..59
//   seconds_out  out  seconds, 0..59
//   tick_o       out  one-cycle pulse, coincident with each run-mode seconds advance
//   set_mode_o   out  registered mode state: 1 = set mode
// -----------------------------------------------------------------------------
module bin_clock_timekeeper #(
    parameter int CLK_HZ      = 10_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = CLK_HZ / 2,
    parameter int RPT_CYC     = CLK_HZ / 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       time_set,
    input  logic       id_switch,
    input  logic       hour_id,
    input  logic       minute_id,
    input  logic       seconds_id,
    output logic [3:0] hour_out,
    output logic [5:0] minute_out,
    output logic [5:0] seconds_out,
    output logic       tick_o,
    output logic       set_mode_o
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);

    // Repeat counter: counts 0..HOLD_CYC while a press is held, then cycles
    // through the last RPT_CYC values so a repeat fires every RPT_CYC cycles.
    localparam int CNT_W = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(HOLD_CYC - RPT_CYC + 1);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } mode_e;

    // Bit order of the synchronizer word: {seconds, minute, hour, id, time_set}
    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0]                  sync_lvl;
    logic                        time_set_s;
    logic                        id_s;
    logic [2:0]                  btn_s;      // {seconds, minute, hour}
    logic [2:0]                  btn_q;
    logic [2:0]                  press;
    logic [2:0]                  adj;
    logic [CNT_W-1:0]            rpt_cnt [3];

    mode_e                       state;
    mode_e                       state_next;

    logic [PRE_W-1:0]            presc;
    logic                        wrap;

    logic [3:0]                  hour_nx;
    logic [5:0]                  minute_nx;
    logic [5:0]                  seconds_nx;

    // ---------------------------------------------------------------- helpers
    // Illegal field values snap back to their reset value on any update.
    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec60(input logic [5:0] v);
        if (v == 6'd0)  return 6'd59;
        if (v > 6'd59)  return 6'd0;
        return v - 6'd1;
    endfunction

    function automatic logic [3:0] inc_hr(input logic [3:0] h);
        if (h == 4'd0 || h > 4'd12) return 4'd12;
        if (h == 4'd12)             return 4'd1;
        return h + 4'd1;
    endfunction

    function automatic logic [3:0] dec_hr(input logic [3:0] h);
        if (h == 4'd0 || h > 4'd12) return 4'd12;
        if (h == 4'd1)              return 4'd12;
        return h - 4'd1;
    endfunction

    // ---------------------------------------------------------- synchronizers
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {seconds_id, minute_id, hour_id, id_switch, time_set};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_lvl   = sync_q[SYNC_STAGES-1];
    assign time_set_s = sync_lvl[0];
    assign id_s       = sync_lvl[1];
    assign btn_s      = sync_lvl[4:2];

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (time_set_s)  state_next = ST_SET;
            ST_SET:  if (!time_set_s) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    assign set_mode_o = (state == ST_SET);

    // ------------------------------------------------------ button pulses
    // The edge register follows the synchronized level in both modes, so a
    // button already held when set mode begins never produces a rising edge.
    always_comb begin
        press = btn_s & ~btn_q;
        adj   = '0;
        for (int i = 0; i < 3; i++) begin
            adj[i] = set_mode_o & btn_s[i] & (press[i] | (rpt_cnt[i] == HOLD_TC));
        end
    end

    // NOTE: the per-button counters are a handful of flops, not a RAM, so they
    // are cleared element by element in reset like any other register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_q <= '0;
            for (int i = 0; i < 3; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            btn_q <= btn_s;
            for (int i = 0; i < 3; i++) begin
                if (!btn_s[i] || !set_mode_o) begin
                    rpt_cnt[i] <= '0;
                end else if (press[i] || rpt_cnt[i] != '0) begin
                    // Only a genuine press arms the counter; a held-over
                    // button leaves it parked at zero.
                    rpt_cnt[i] <= (rpt_cnt[i] == HOLD_TC) ? RPT_RELOAD
                                                          : rpt_cnt[i] + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------- prescaler
    assign wrap = (state == ST_RUN) && (presc == PRE_TC);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc  <= '0;
            tick_o <= 1'b0;
        end else begin
            // Registered tick rises on the same edge the seconds advance.
            tick_o <= wrap;
            if (state == ST_SET || wrap) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ time fields
    always_comb begin
        hour_nx    = hour_out;
        minute_nx  = minute_out;
        seconds_nx = seconds_out;
        if (wrap) begin
            // Full carry ripple lands on a single edge.
            seconds_nx = inc60(seconds_out);
            if (seconds_out == 6'd59) begin
                minute_nx = inc60(minute_out);
                if (minute_out == 6'd59) begin
                    hour_nx = inc_hr(hour_out);
                end
            end
        end else begin
            // Set mode: fields move independently, no carry between them.
            if (adj[0]) hour_nx    = id_s ? inc_hr(hour_out)   : dec_hr(hour_out);
            if (adj[1]) minute_nx  = id_s ? inc60(minute_out)  : dec60(minute_out);
            if (adj[2]) seconds_nx = id_s ? inc60(seconds_out) : dec60(seconds_out);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hour_out    <= 4'd12;
            minute_out  <= 6'd0;
            seconds_out <= 6'd0;
        end else begin
            hour_out    <= hour_nx;
            minute_out  <= minute_nx;
            seconds_out <= seconds_nx;
        end
    end

endmodule

// File: tb/tb_bin_clock_timekeeper.sv
// -----------------------------------------------------------------------------
// tb_bin_clock_timekeeper
//
// Self-checking bench for bin_clock_timekeeper with a small clock rate. Time is
// modelled as seconds since 12:00:00 on a 12-hour dial; field adjustments and
// ticks are applied to that count with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_bin_clock_timekeeper;

    localparam int CLK_HZ      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYC    = 6;
    localparam int RPT_CYC     = 2;
    localparam int DIAL        = 12 * 3600;
    localparam int F_HR        = 0;
    localparam int F_MIN       = 1;
    localparam int F_SEC       = 2;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       time_set   = 1'b0;
    logic       id_switch  = 1'b0;
    logic       hour_id    = 1'b0;
    logic       minute_id  = 1'b0;
    logic       seconds_id = 1'b0;
    logic [3:0] hour_out;
    logic [5:0] minute_out;
    logic [5:0] seconds_out;
    logic       tick_o;
    logic       set_mode_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_t     = 0;   // seconds since 12:00:00
    int m_phase = 0;   // cycles into the current second
    bit m_tick  = 1'b0;
    bit m_mode  = 1'b0;
    bit ts_pipe [SYNC_STAGES];
    bit track_time = 1'b1;

    bin_clock_timekeeper #(
        .CLK_HZ      (CLK_HZ),
        .SYNC_STAGES (SYNC_STAGES),
        .HOLD_CYC    (HOLD_CYC),
        .RPT_CYC     (RPT_CYC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .time_set    (time_set),
        .id_switch   (id_switch),
        .hour_id     (hour_id),
        .minute_id   (minute_id),
        .seconds_id  (seconds_id),
        .hour_out    (hour_out),
        .minute_out  (minute_out),
        .seconds_out (seconds_out),
        .tick_o      (tick_o),
        .set_mode_o  (set_mode_o)
    );

    always #5 clk = ~clk;

    function automatic int f_hr(input int t);
        return (t / 3600 == 0) ? 12 : t / 3600;
    endfunction

    function automatic int f_min(input int t);
        return (t / 60) % 60;
    endfunction

    function automatic int f_sec(input int t);
        return t % 60;
    endfunction

    function automatic int field_of(input int t, input int field);
        case (field)
            F_HR:    return f_hr(t);
            F_MIN:   return f_min(t);
            default: return f_sec(t);
        endcase
    endfunction

    // Hour 12 is stored as 0, so 12-hour wrapping is plain modulo-12.
    function automatic int adjust(input int t, input int field, input bit up);
        int h = t / 3600;
        int m = (t / 60) % 60;
        int s = t % 60;
        case (field)
            F_HR:    h = up ? (h + 1) % 12 : (h + 11) % 12;
            F_MIN:   m = up ? (m + 1) % 60 : (m + 59) % 60;
            default: s = up ? (s + 1) % 60 : (s + 59) % 60;
        endcase
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag);
        check({tag, ".hour"},    32'(hour_out),    32'(f_hr(m_t)));
        check({tag, ".minute"},  32'(minute_out),  32'(f_min(m_t)));
        check({tag, ".seconds"}, 32'(seconds_out), 32'(f_sec(m_t)));
    endtask

    // One clock edge: advance the model with the inputs seen at that edge,
    // then compare just after it.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_t     = 0;
            m_phase = 0;
            m_tick  = 1'b0;
            m_mode  = 1'b0;
            foreach (ts_pipe[i]) ts_pipe[i] = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (!m_mode) begin
                if (m_phase == CLK_HZ - 1) begin
                    m_phase = 0;
                    m_t     = (m_t + 1) % DIAL;
                    m_tick  = 1'b1;
                end else begin
                    m_phase++;
                end
            end else begin
                m_phase = 0;
            end
            // Mode follows time_set after the synchronizer delay.
            m_mode = ts_pipe[SYNC_STAGES-1];
            for (int i = SYNC_STAGES - 1; i > 0; i--) ts_pipe[i] = ts_pipe[i-1];
            ts_pipe[0] = time_set;
        end
        #1;
        check("tick_o", 32'(tick_o), 32'(m_tick));
        check("set_mode_o", 32'(set_mode_o), 32'(m_mode));
        if (track_time) check_time("time");
    endtask

    task automatic set_id(input bit up);
        id_switch = up;
        repeat (SYNC_STAGES + 1) step();
    endtask

    task automatic apply_press(input bit b_hr, input bit b_min, input bit b_sec, input int n);
        repeat (n) begin
            if (b_hr)  m_t = adjust(m_t, F_HR,  id_switch);
            if (b_min) m_t = adjust(m_t, F_MIN, id_switch);
            if (b_sec) m_t = adjust(m_t, F_SEC, id_switch);
        end
    endtask

    // Hold the chosen buttons for len cycles (set mode), release, let the last
    // update land, then apply 1 press plus any auto-repeats to the model.
    task automatic press(input bit b_hr, input bit b_min, input bit b_sec, input int len);
        int n;
        track_time = 1'b0;
        hour_id    = b_hr;
        minute_id  = b_min;
        seconds_id = b_sec;
        repeat (len) step();
        hour_id    = 1'b0;
        minute_id  = 1'b0;
        seconds_id = 1'b0;
        repeat (SYNC_STAGES + 1) step();
        n = 1 + ((len > HOLD_CYC) ? (len - HOLD_CYC - 1) / RPT_CYC + 1 : 0);
        apply_press(b_hr, b_min, b_sec, n);
        track_time = 1'b1;
        check_time("press");
    endtask

    // One-cycle press; the fields must hold through edge 2 and change on edge
    // 3 counted from the edge that samples the raw button.
    task automatic press_latency(input bit b_hr, input bit b_min, input bit b_sec);
        hour_id    = b_hr;
        minute_id  = b_min;
        seconds_id = b_sec;
        step();
        hour_id    = 1'b0;
        minute_id  = 1'b0;
        seconds_id = 1'b0;
        step();
        check_time("latency.before");
        apply_press(b_hr, b_min, b_sec, 1);
        step();
        check_time("latency.after");
        repeat (2) step();
    endtask

    task automatic set_field_to(input int field, input int target);
        int k = 0;
        while (field_of(m_t, field) != target && k < 60) begin
            press(field == F_HR, field == F_MIN, field == F_SEC, 1);
            k++;
        end
        check("set_field_to", 32'(field_of(m_t, field)), 32'(target));
    endtask

    task automatic wait_mode(input bit v, input string tag);
        int k = 0;
        while (set_mode_o !== v && k < 10) begin
            step();
            k++;
        end
        check(tag, 32'(set_mode_o), 32'(v));
    endtask

    task automatic cycles_to_tick(input string tag, input int exp);
        int k = 0;
        do begin
            step();
            k++;
        end while (tick_o !== 1'b1 && k < 3 * CLK_HZ);
        check(tag, 32'(k), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        foreach (ts_pipe[i]) ts_pipe[i] = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst.hour",     32'(hour_out),    32'd12);
        check("rst.minute",   32'(minute_out),  32'd0);
        check("rst.seconds",  32'(seconds_out), 32'd0);
        check("rst.tick",     32'(tick_o),      32'd0);
        check("rst.set_mode", 32'(set_mode_o),  32'd0);
        rst = 1'b0;

        // Free run: tick every CLK_HZ cycles, seconds advance with it
        cycles_to_tick("first_tick_after_reset", CLK_HZ);
        cycles_to_tick("tick_period", CLK_HZ);
        repeat (30) step();

        // Enter set mode
        time_set = 1'b1;
        wait_mode(1'b1, "enter_set");
        repeat (2) step();

        // Minute dec wrap 0->59, then inc wrap 59->0 with exact latency
        set_id(1'b0);
        press(1'b0, 1'b1, 1'b0, 1);
        check("min_dec_wrap", 32'(minute_out), 32'd59);
        set_id(1'b1);
        press_latency(1'b0, 1'b1, 1'b0);
        check("min_inc_wrap", 32'(minute_out), 32'd0);
        check("min_wrap_no_carry", 32'(hour_out), 32'd12);

        // Hour 12->1 up, 1->12 down
        press(1'b1, 1'b0, 1'b0, 1);
        check("hr_inc_wrap", 32'(hour_out), 32'd1);
        set_id(1'b0);
        press(1'b1, 1'b0, 1'b0, 1);
        check("hr_dec_wrap", 32'(hour_out), 32'd12);

        // Seconds down to 0, then hour and seconds together on one edge
        set_field_to(F_SEC, 0);
        press_latency(1'b1, 1'b0, 1'b1);
        check("dual.hour",    32'(hour_out),    32'd11);
        check("dual.seconds", 32'(seconds_out), 32'd59);

        // Auto-repeat: 12-cycle hold from 10 gives press + 3 repeats
        set_id(1'b1);
        set_field_to(F_MIN, 10);
        press(1'b0, 1'b1, 1'b0, 12);
        check("auto_repeat", 32'(minute_out), 32'd14);

        // Randomized presses
        for (int r = 0; r < 12; r++) begin
            bit [2:0] f;
            int       len;
            bit       up;
            f   = 3'($urandom_range(1, 7));
            len = $urandom_range(1, 14);
            up  = 1'($urandom_range(0, 1));
            if (up != id_switch) set_id(up);
            press(f[0], f[1], f[2], len);
        end

        // Button held across RUN->SET: no adjustment, even past HOLD_CYC
        set_id(1'b1);
        time_set = 1'b0;
        wait_mode(1'b0, "leave_set");
        minute_id = 1'b1;
        repeat (4) step();
        time_set = 1'b1;
        wait_mode(1'b1, "reenter_set");
        repeat (HOLD_CYC + 4) step();
        minute_id = 1'b0;
        repeat (3) step();
        check_time("held_into_set");
        press(1'b0, 1'b1, 1'b0, 1);

        // Button held across reset: no adjustment until a fresh press
        hour_id = 1'b1;
        rst     = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (HOLD_CYC + 6) step();
        hour_id = 1'b0;
        repeat (3) step();
        check("held_thru_reset.hour", 32'(hour_out), 32'd12);
        check("held_thru_reset.mode", 32'(set_mode_o), 32'd1);
        press(1'b1, 1'b0, 1'b0, 1);
        check("fresh_press.hour", 32'(hour_out), 32'd1);

        // Full carry 12:59:59 -> 1:00:00, and first tick CLK_HZ after leaving SET
        set_field_to(F_HR, 12);
        set_field_to(F_MIN, 59);
        set_field_to(F_SEC, 58);
        time_set = 1'b0;
        wait_mode(1'b0, "leave_set_carry");
        cycles_to_tick("first_tick_after_set", CLK_HZ);
        repeat (CLK_HZ - 1) step();
        check("pre_carry.hour",    32'(hour_out),    32'd12);
        check("pre_carry.minute",  32'(minute_out),  32'd59);
        check("pre_carry.seconds", 32'(seconds_out), 32'd59);
        step();
        check("carry.hour",    32'(hour_out),    32'd1);
        check("carry.minute",  32'(minute_out),  32'd0);
        check("carry.seconds", 32'(seconds_out), 32'd0);
        check("carry.tick",    32'(tick_o),      32'd1);

        // Reset mid-count: back to 12:00:00 with the prescaler at zero
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst.hour",    32'(hour_out),    32'd12);
        check("mid_rst.minute",  32'(minute_out),  32'd0);
        check("mid_rst.seconds", 32'(seconds_out), 32'd0);
        cycles_to_tick("tick_after_mid_rst", CLK_HZ);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
